// File: rtl/cc_speed_counter.sv
// cc_speed_counter: speed prescaler for the game core.
// Holds a 3-bit speed level (accelerate/brake edges), counts from a
// level-dependent preload up to all-ones, reloads when the comparator
// reports terminal count and emits a one-cycle game tick.
// Optional build macro: CC_SPEEDCOUNTER_RATELIMIT_EN limits level changes
// to one per tick period while running.
module cc_speed_counter #(
   parameter int unsigned SPEEDCOUNTER_DATAWIDTH  = 23,
   parameter int unsigned SPEEDCOUNTER_BASEPERIOD = 4194304
) (
   input  logic                              CC_SPEEDCOUNTER_CLOCK_50,
   input  logic                              CC_SPEEDCOUNTER_RESET_InHigh,
   input  logic                              CC_SPEEDCOUNTER_T0_InLow,
   input  logic                              CC_SPEEDCOUNTER_accel_InHigh,
   input  logic                              CC_SPEEDCOUNTER_brake_InHigh,
   input  logic                              CC_SPEEDCOUNTER_pause_InHigh,
   output logic [SPEEDCOUNTER_DATAWIDTH-1:0] CC_SPEEDCOUNTER_data_OutBUS,
   output logic                              CC_SPEEDCOUNTER_tick_OutHigh,
   output logic [2:0]                        CC_SPEEDCOUNTER_level_OutBUS,
   output logic                              CC_SPEEDCOUNTER_running_OutHigh
);

   localparam int unsigned W = SPEEDCOUNTER_DATAWIDTH;
   localparam logic [2:0] LEVEL_MAX = 3'd7;

   typedef enum logic [1:0] {
      STATE_STOP  = 2'd0,
      STATE_RUN   = 2'd1,
      STATE_PAUSE = 2'd2
   } speedState_t;

   speedState_t state;
   speedState_t stateNext;

   logic [W-1:0] dataReg;
   logic [W-1:0] dataNext;
   logic         tickReg;
   logic         tickNext;
   logic [2:0]   levelReg;
   logic [2:0]   levelNext;
   logic         runningReg;

   logic accelPrev;
   logic brakePrev;
   logic accelEdge;
   logic brakeEdge;
   logic accelOnly;
   logic brakeOnly;
   logic changeAllowed;

   // Preload for a level: 2^W - (BASE >> (L-1)), formed in W+1 bits then truncated.
   function automatic logic [W-1:0] preloadOf(input logic [2:0] lvl);
      logic [W:0] period;
      logic [W:0] fullScale;
      logic [2:0] shiftAmt;
      shiftAmt  = (lvl == 3'd0) ? 3'd0 : (lvl - 3'd1);
      period    = (W+1)'(SPEEDCOUNTER_BASEPERIOD) >> shiftAmt;
      fullScale = (W+1)'(1) << W;
      preloadOf = W'(fullScale - period);
   endfunction

   // Rising edges of the control requests; simultaneous accel and brake cancel out.
   assign accelEdge = CC_SPEEDCOUNTER_accel_InHigh & ~accelPrev;
   assign brakeEdge = CC_SPEEDCOUNTER_brake_InHigh & ~brakePrev;
   assign accelOnly = accelEdge & ~brakeEdge;
   assign brakeOnly = brakeEdge & ~accelEdge;

`ifdef CC_SPEEDCOUNTER_RATELIMIT_EN
   logic acceptFlag;

   // Accept flag: armed in STOP and on every reload, dropped by an accepted level change.
   always_ff @(posedge CC_SPEEDCOUNTER_CLOCK_50 or posedge CC_SPEEDCOUNTER_RESET_InHigh) begin
      if (CC_SPEEDCOUNTER_RESET_InHigh) begin
         acceptFlag <= 1'b1;
      end else if (tickNext || (state == STATE_STOP)) begin
         acceptFlag <= 1'b1;
      end else if ((state == STATE_RUN) && (levelNext != levelReg)) begin
         acceptFlag <= 1'b0;
      end
   end

   assign changeAllowed = acceptFlag;
`else
   assign changeAllowed = 1'b1;
`endif

   // Edge-detect history registers.
   always_ff @(posedge CC_SPEEDCOUNTER_CLOCK_50 or posedge CC_SPEEDCOUNTER_RESET_InHigh) begin
      if (CC_SPEEDCOUNTER_RESET_InHigh) begin
         accelPrev <= 1'b0;
         brakePrev <= 1'b0;
      end else begin
         accelPrev <= CC_SPEEDCOUNTER_accel_InHigh;
         brakePrev <= CC_SPEEDCOUNTER_brake_InHigh;
      end
   end

   // State and registered outputs.
   always_ff @(posedge CC_SPEEDCOUNTER_CLOCK_50 or posedge CC_SPEEDCOUNTER_RESET_InHigh) begin
      if (CC_SPEEDCOUNTER_RESET_InHigh) begin
         state      <= STATE_STOP;
         dataReg    <= '0;
         tickReg    <= 1'b0;
         levelReg   <= 3'd0;
         runningReg <= 1'b0;
      end else begin
         state      <= stateNext;
         dataReg    <= dataNext;
         tickReg    <= tickNext;
         levelReg   <= levelNext;
         runningReg <= (stateNext == STATE_RUN);
      end
   end

   // Next-state, count, tick and level logic; the running period always finishes at its old level.
   always_comb begin
      stateNext = state;
      dataNext  = dataReg;
      tickNext  = 1'b0;
      levelNext = levelReg;

      case (state)
         STATE_STOP: begin
            dataNext = '0;
            if (accelOnly) begin
               stateNext = STATE_RUN;
               levelNext = 3'd1;
               dataNext  = preloadOf(3'd1);
            end
         end

         STATE_RUN: begin
            if (CC_SPEEDCOUNTER_pause_InHigh) begin
               stateNext = STATE_PAUSE;
            end else if (brakeOnly && changeAllowed && (levelReg == 3'd1)) begin
               // Dropping out of level 1 discards any tick that would have fired here.
               stateNext = STATE_STOP;
               levelNext = 3'd0;
               dataNext  = '0;
            end else begin
               if (!CC_SPEEDCOUNTER_T0_InLow) begin
                  dataNext = preloadOf(levelReg);
                  tickNext = 1'b1;
               end else begin
                  dataNext = dataReg + W'(1);
               end

               if (accelOnly && changeAllowed && (levelReg != LEVEL_MAX)) begin
                  levelNext = levelReg + 3'd1;
               end else if (brakeOnly && changeAllowed) begin
                  levelNext = levelReg - 3'd1;
               end
            end
         end

         STATE_PAUSE: begin
            if (!CC_SPEEDCOUNTER_pause_InHigh) begin
               stateNext = STATE_RUN;
            end
         end

         default: begin
            stateNext = STATE_STOP;
            dataNext  = '0;
            levelNext = 3'd0;
         end
      endcase
   end

   assign CC_SPEEDCOUNTER_data_OutBUS     = dataReg;
   assign CC_SPEEDCOUNTER_tick_OutHigh    = tickReg;
   assign CC_SPEEDCOUNTER_level_OutBUS    = levelReg;
   assign CC_SPEEDCOUNTER_running_OutHigh = runningReg;

endmodule

// File: tb/tb_cc_speed_counter.sv
// Testbench for cc_speed_counter at W=8, BASEPERIOD=64 with an all-ones
// comparator model closing the terminal-count loop.
module tb_cc_speed_counter;

   localparam int unsigned W    = 8;
   localparam int unsigned BASE = 64;

   logic         clk;
   logic         rst;
   logic         t0Low;
   logic         accel;
   logic         brake;
   logic         pause;
   logic [W-1:0] data;
   logic         tick;
   logic [2:0]   level;
   logic         running;

   int cmpCount = 0;
   int errCount = 0;

   typedef struct {
      logic         accel;
      logic         brake;
      logic         pause;
      logic [W-1:0] expData;
      logic         expTick;
      logic [2:0]   expLevel;
      logic         expRunning;
   } vec_t;

   vec_t vecs [13];

   cc_speed_counter #(
      .SPEEDCOUNTER_DATAWIDTH (W),
      .SPEEDCOUNTER_BASEPERIOD(BASE)
   ) dut (
      .CC_SPEEDCOUNTER_CLOCK_50       (clk),
      .CC_SPEEDCOUNTER_RESET_InHigh   (rst),
      .CC_SPEEDCOUNTER_T0_InLow       (t0Low),
      .CC_SPEEDCOUNTER_accel_InHigh   (accel),
      .CC_SPEEDCOUNTER_brake_InHigh   (brake),
      .CC_SPEEDCOUNTER_pause_InHigh   (pause),
      .CC_SPEEDCOUNTER_data_OutBUS    (data),
      .CC_SPEEDCOUNTER_tick_OutHigh   (tick),
      .CC_SPEEDCOUNTER_level_OutBUS   (level),
      .CC_SPEEDCOUNTER_running_OutHigh(running)
   );

   // Comparator: terminal flag low when the count is all-ones.
   assign t0Low = ~(&data);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      cmpCount++;
      if (act != exp) begin
         errCount++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic doReset();
      accel = 1'b0;
      brake = 1'b0;
      pause = 1'b0;
      rst   = 1'b1;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic accelPulse();
      accel = 1'b1;
      step();
      accel = 1'b0;
      step();
   endtask

   task automatic brakePulse();
      brake = 1'b1;
      step();
      brake = 1'b0;
      step();
   endtask

   task automatic waitTick(input string name);
      int n = 0;
      do begin
         step();
         n++;
      end while (tick !== 1'b1 && n < 100);
      check(name, tick, 1);
   endtask

   task automatic waitData(input string name, input logic [W-1:0] target);
      int n = 0;
      do begin
         step();
         n++;
      end while (data !== target && n < 100);
      check(name, data, target);
   endtask

   initial begin
      rst   = 1'b1;
      accel = 1'b0;
      brake = 1'b0;
      pause = 1'b0;

      //                accel brake pause data   tick lvl  run
      vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'hC0, 1'b0, 3'd1, 1'b1};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'hC1, 1'b0, 3'd1, 1'b1};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'hC2, 1'b0, 3'd1, 1'b1};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'hC3, 1'b0, 3'd2, 1'b1};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'hC4, 1'b0, 3'd2, 1'b1};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'hC5, 1'b0, 3'd2, 1'b1};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'hC6, 1'b0, 3'd2, 1'b1};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'hC6, 1'b0, 3'd2, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 1'b1, 8'hC6, 1'b0, 3'd2, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 8'hC6, 1'b0, 3'd2, 1'b1};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 8'hC7, 1'b0, 3'd2, 1'b1};

      step();
      check("reset_data", data, 0);
      check("reset_tick", tick, 0);
      check("reset_level", level, 0);
      check("reset_running", running, 0);
      rst = 1'b0;
      step();

      // Table: STOP ignores brake/pause, start, edges, both-edge cancel, pause.
      for (int i = 0; i < 13; i++) begin
         accel = vecs[i].accel;
         brake = vecs[i].brake;
         pause = vecs[i].pause;
         step();
         check($sformatf("vec%0d_data", i), data, vecs[i].expData);
         check($sformatf("vec%0d_tick", i), tick, vecs[i].expTick);
         check($sformatf("vec%0d_level", i), level, vecs[i].expLevel);
         check($sformatf("vec%0d_running", i), running, vecs[i].expRunning);
      end

      // Async reset mid-count at level 3.
      waitTick("t1_tick");
      accelPulse();
      check("t1_level3", level, 3);
      step();
      step();
      #2;
      rst = 1'b1;
      #1;
      check("t1_async_data", data, 0);
      check("t1_async_level", level, 0);
      check("t1_async_tick", tick, 0);
      check("t1_async_running", running, 0);
      step();
      rst = 1'b0;
      step();
      check("t1_after_data", data, 0);
      check("t1_after_running", running, 0);

      // Level 1: C0..FF then tick with reload, every 64 cycles.
      doReset();
      accelPulse();
      check("t2_start_data", data, 8'hC1);
      for (int k = 2; k <= 130; k++) begin
         logic [W-1:0] expD;
         expD = W'(8'hC0 + (k % 64));
         step();
         check($sformatf("t2_data_k%0d", k), data, expD);
         check($sformatf("t2_tick_k%0d", k), tick, (k % 64) == 0);
      end

      // Saturation at level 7: preload all-ones, tick every cycle.
      doReset();
      accelPulse();
      for (int i = 0; i < 7; i++) begin
         waitTick("t3_tick");
         accelPulse();
      end
      check("t3_level_sat", level, 7);
      waitTick("t3_tick_l7");
      for (int i = 0; i < 6; i++) begin
         step();
         check("t3_tick_cont", tick, 1);
         check("t3_data_ff", data, 8'hFF);
         check("t3_level_hold", level, 7);
      end

      // Level 2 pause at E5 with an accel edge inside the pause.
      doReset();
      accelPulse();
      waitTick("t4_tick_l1");
      accelPulse();
      waitTick("t4_tick_l2");
      check("t4_reload_e0", data, 8'hE0);
      waitData("t4_reach_e5", 8'hE5);
      pause = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("t4_pause_data", data, 8'hE5);
         check("t4_pause_tick", tick, 0);
         check("t4_pause_level", level, 2);
         check("t4_pause_running", running, 0);
         if (i == 3) accel = 1'b1;
         if (i == 6) accel = 1'b0;
      end
      pause = 1'b0;
      step();
      check("t4_resume_data", data, 8'hE5);
      check("t4_resume_running", running, 1);
      for (int k = 1; k <= 26; k++) begin
         step();
         check("t4_count", data, 8'hE5 + k);
         check("t4_notick", tick, 0);
      end
      step();
      check("t4_tick", tick, 1);
      check("t4_tick_reload", data, 8'hE0);
      check("t4_level_kept", level, 2);

      // Both edges at level 4, brake down to STOP dropping a pending tick.
      doReset();
      accelPulse();
      for (int i = 0; i < 3; i++) begin
         waitTick("t5_up_tick");
         accelPulse();
      end
      check("t5_level4", level, 4);
      accel = 1'b1;
      brake = 1'b1;
      step();
      accel = 1'b0;
      brake = 1'b0;
      step();
      check("t5_both_level", level, 4);
      for (int i = 0; i < 3; i++) begin
         waitTick("t5_dn_tick");
         brakePulse();
      end
      check("t5_level1", level, 1);
      waitTick("t5_tick_l1");
      waitData("t5_reach_ff", 8'hFF);
      brake = 1'b1;
      step();
      check("t5_stop_data", data, 0);
      check("t5_stop_tick", tick, 0);
      check("t5_stop_level", level, 0);
      check("t5_stop_running", running, 0);
      brake = 1'b0;
      step();
      brake = 1'b1;
      step();
      brake = 1'b0;
      step();
      check("t5_brake_stop_level", level, 0);
      check("t5_brake_stop_data", data, 0);
      check("t5_brake_stop_running", running, 0);

      // Two accel edges within one period, then one after the next tick.
      doReset();
      accelPulse();
      waitTick("t6_tick_l1");
      accelPulse();
      waitTick("t6_tick_l2");
      accelPulse();
      accelPulse();
`ifdef CC_SPEEDCOUNTER_RATELIMIT_EN
      check("t6_limited_level", level, 3);
`else
      check("t6_free_level", level, 4);
`endif
      waitTick("t6_tick_next");
      accelPulse();
`ifdef CC_SPEEDCOUNTER_RATELIMIT_EN
      check("t6_after_tick_level", level, 4);
`else
      check("t6_after_tick_level", level, 5);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
      $finish;
   end

endmodule
